text_buffer_writer: RTL and testbench
=====================================

Name: text_buffer_writer

Overview:
- Converts an incoming ASCII byte stream (UART receiver or keyboard decoder) into write cycles on port A of the 80x25 text-screen RAM. The display scanner reads the same RAM on port B.
- Maintains the cursor and handles printable characters, carriage return and backspace, with wrap-around.
- Provides a full-screen clear, which writes spaces to every cell.

Parameters:
ADDR_WIDTH, 11, RAM address width; must satisfy 2**ADDR_WIDTH >= COLS*ROWS
DATA_WIDTH, 8, character width
COLS, 80, characters per row
ROWS, 25, rows per screen

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rx_data  input  DATA_WIDTH  incoming character
rx_valid  input  1  rx_data valid
rx_ready  output  1  block can accept a byte; a byte transfers on an edge where rx_valid & rx_ready
clr  input  1  clear-screen request, level-sampled in IDLE
we  output  1  RAM port A write enable
din  output  DATA_WIDTH  RAM port A write data
addr_a  output  ADDR_WIDTH  RAM port A address
cursor_addr  output  ADDR_WIDTH  current cursor linear address (row*COLS+col)
busy  output  1  clear in progress

Behaviour:
- One clock domain: clk.
- Reset is asynchronous and active-low (rst_n).
- Asserting rst_n low forces immediately: we=0, din=0, addr_a=0, cursor_addr=0, rx_ready=0, busy=0, state=IDLE, and the internal row and col counters to 0.
- All outputs are registered.
- rx_ready rises on the first clk edge after rst_n deasserts.
- Cursor tracking:
  - col is 0..COLS-1 and row is 0..ROWS-1.
  - cursor_addr is updated incrementally; no multiplier or divider is used.
  - The last cell is LAST=COLS*ROWS-1, which is 1999 by default.
- States: IDLE, WRITE, CLEAR.
- IDLE with clr=1:
  - clr has priority over rx_valid in the same cycle; the byte is not accepted.
  - Next state CLEAR; rx_ready<=0, busy<=1, clear counter<=0.
- IDLE with rx_valid & rx_ready, transfer at edge k. The action at edge k depends on the byte:
  - Printable 0x20..0x7E: we<=1, addr_a<=cursor_addr, din<=rx_data. Cursor advances by one: col+1, or col=0 and row+1 at end of row. At LAST the cursor wraps to 0.
  - 0x0D (CR): no write. Cursor moves to col=0, row+1; from row ROWS-1 it goes to row 0.
  - 0x08 (BS): if cursor_addr != 0, cursor decrements (from col 0 it goes to col COLS-1 of row-1), and we<=1, din<=0x20, addr_a<=new cursor. At cursor_addr 0 nothing changes and no write occurs.
  - Any other byte, including 0x0A: discarded, no write, no cursor change.
  - In all cases: state<=WRITE, rx_ready<=0.
- WRITE: at edge k+1, we<=0, rx_ready<=1, state<=IDLE. Every write pulse is therefore exactly one cycle.
  - Minimum spacing between accepted bytes is 2 cycles.
  - 0x0D never appears on din with we=1.
- CLEAR:
  - Each cycle: we=1, din=0x20, addr_a=counter.
  - The counter runs 0..LAST, one cell per cycle, so a clear lasts COLS*ROWS cycles with we high.
  - On the edge after writing LAST: we<=0, busy<=0, cursor, row and col<=0, rx_ready<=1, state<=IDLE.
  - clr and rx_valid are ignored while in CLEAR.
- Reset during WRITE or CLEAR aborts the operation immediately; any partial clear leaves the RAM partly written.
- cursor_addr is always in 0..LAST.

Test Plan:
- Reset release, then send 'A' (0x41) at cursor 0 -> one-cycle we pulse with addr_a=0, din=0x41; cursor_addr=1; rx_ready low for exactly 1 cycle.
- Send 0x41,0x42 with rx_valid held high -> writes at addr 0 and 1 on cycles 2 apart; cursor_addr=2.
- Cursor at 5, send 0x0D -> no we pulse; cursor_addr=80. Cursor at 1990 (row 24), send 0x0D -> cursor_addr=0.
- Cursor at 80, send 0x08 -> we with addr_a=79, din=0x20; cursor_addr=79. Cursor at 0, send 0x08 -> no we, cursor stays 0.
- Cursor at 1999, send 'Z' -> write addr 1999, din=0x5A; cursor_addr wraps to 0. Send 0x0A and 0x07 -> no writes, cursor unchanged.
- Assert clr together with rx_valid (byte 0x41) -> byte not accepted. busy=1 and we=1 for exactly 2000 cycles, addr_a sweeping 0..1999 with din=0x20. Then busy=0, cursor_addr=0, rx_ready=1. Pulling rst_n low mid-clear (at addr 700) drops we and busy immediately.

Source files
------------

// File: rtl/text_buffer_writer.sv
// ASCII stream to 80x25 text RAM port A writer.
// Tracks the cursor, handles CR/BS with wrap, and clears the screen.
module text_buffer_writer #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int COLS       = 80,
  parameter int ROWS       = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  clr,
  output logic                  we,
  output logic [DATA_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] cursor_addr,
  output logic                  busy
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam addr_t LAST  = addr_t'(COLS * ROWS - 1);
  localparam addr_t CMAX  = addr_t'(COLS - 1);
  localparam addr_t RMAX  = addr_t'(ROWS - 1);
  localparam addr_t NCOL  = addr_t'(COLS);
  localparam addr_t ONE   = addr_t'(1);
  localparam data_t CH_SP = data_t'(8'h20);
  localparam data_t CH_TL = data_t'(8'h7E);
  localparam data_t CH_CR = data_t'(8'h0D);
  localparam data_t CH_BS = data_t'(8'h08);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_CLEAR
  } state_t;

  state_t r_state, w_state;
  logic   r_we, w_we;
  logic   r_rdy, w_rdy;
  logic   r_busy, w_busy;
  data_t  r_din, w_din;
  addr_t  r_addr, w_addr;
  addr_t  r_cur, w_cur;
  addr_t  r_row, w_row;
  addr_t  r_col, w_col;
  addr_t  r_cnt, w_cnt;

  logic   w_take;
  logic   w_prn;
  logic   w_cr;
  logic   w_bs;

  assign w_take = rx_valid & r_rdy;
  assign w_prn  = (rx_data >= CH_SP) && (rx_data <= CH_TL);
  assign w_cr   = (rx_data == CH_CR);
  assign w_bs   = (rx_data == CH_BS);

  // Register every output and the cursor/clear state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
      r_din   <= '0;
      r_addr  <= '0;
      r_cur   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_we    <= w_we;
      r_rdy   <= w_rdy;
      r_busy  <= w_busy;
      r_din   <= w_din;
      r_addr  <= w_addr;
      r_cur   <= w_cur;
      r_row   <= w_row;
      r_col   <= w_col;
      r_cnt   <= w_cnt;
    end
  end

  // Next-state: byte decode, cursor moves and clear sweep.
  always_comb begin
    w_state = r_state;
    w_we    = r_we;
    w_rdy   = r_rdy;
    w_busy  = r_busy;
    w_din   = r_din;
    w_addr  = r_addr;
    w_cur   = r_cur;
    w_row   = r_row;
    w_col   = r_col;
    w_cnt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        w_we = 1'b0;
        if (clr) begin
          w_state = S_CLEAR;
          w_rdy   = 1'b0;
          w_busy  = 1'b1;
          w_cnt   = '0;
          w_we    = 1'b1;
          w_din   = CH_SP;
          w_addr  = '0;
        end else if (w_take) begin
          w_state = S_WRITE;
          w_rdy   = 1'b0;
          unique case (1'b1)
            w_prn: begin
              w_we   = 1'b1;
              w_addr = r_cur;
              w_din  = rx_data;
              if (r_cur == LAST) begin
                w_cur = '0;
                w_row = '0;
                w_col = '0;
              end else if (r_col == CMAX) begin
                w_cur = r_cur + ONE;
                w_row = r_row + ONE;
                w_col = '0;
              end else begin
                w_cur = r_cur + ONE;
                w_col = r_col + ONE;
              end
            end
            w_cr: begin
              w_col = '0;
              if (r_row == RMAX) begin
                w_row = '0;
                w_cur = '0;
              end else begin
                w_row = r_row + ONE;
                w_cur = r_cur - r_col + NCOL;
              end
            end
            w_bs: begin
              if (r_cur != '0) begin
                w_cur  = r_cur - ONE;
                w_we   = 1'b1;
                w_din  = CH_SP;
                w_addr = r_cur - ONE;
                if (r_col == '0) begin
                  w_col = CMAX;
                  w_row = r_row - ONE;
                end else begin
                  w_col = r_col - ONE;
                end
              end
            end
            default: begin
            end
          endcase
        end else begin
          w_rdy = 1'b1;
        end
      end
      S_WRITE: begin
        w_we    = 1'b0;
        w_rdy   = 1'b1;
        w_state = S_IDLE;
      end
      S_CLEAR: begin
        if (r_cnt == LAST) begin
          w_we    = 1'b0;
          w_busy  = 1'b0;
          w_cur   = '0;
          w_row   = '0;
          w_col   = '0;
          w_rdy   = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_we   = 1'b1;
          w_din  = CH_SP;
          w_cnt  = r_cnt + ONE;
          w_addr = r_cnt + ONE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign we          = r_we;
  assign din         = r_din;
  assign addr_a      = r_addr;
  assign cursor_addr = r_cur;
  assign rx_ready    = r_rdy;
  assign busy        = r_busy;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed bench for text_buffer_writer.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_text_buffer_writer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        clr;
  logic        we;
  logic [7:0]  din;
  logic [10:0] addr_a;
  logic [10:0] cursor_addr;
  logic        busy;

  int checks;
  int failures;

  text_buffer_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .clr         (clr),
    .we          (we),
    .din         (din),
    .addr_a      (addr_a),
    .cursor_addr (cursor_addr),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a byte, wait for the transfer edge, return 1ns after it.
  task automatic send(input logic [7:0] b);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 10) begin
      step();
      n++;
    end
    if (!rx_ready)
      check("send_timeout", 32'(rx_ready), 32'd1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++)
      send(b);
  endtask

  initial begin
    int cyc;
    int errs;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    clr      = 1'b0;

    repeat (3) step();
    check("rst_we", 32'(we), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_cursor", 32'(cursor_addr), 32'd0);
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    check("rdy_before_edge", 32'(rx_ready), 32'd0);
    step();
    check("rdy_after_edge", 32'(rx_ready), 32'd1);

    send(8'h41);
    check("A_we", 32'(we), 32'd1);
    check("A_addr", 32'(addr_a), 32'd0);
    check("A_din", 32'(din), 32'h41);
    check("A_cursor", 32'(cursor_addr), 32'd1);
    check("A_rdy_low", 32'(rx_ready), 32'd0);
    step();
    check("A_we_drop", 32'(we), 32'd0);
    check("A_rdy_back", 32'(rx_ready), 32'd1);

    send(8'h08);
    check("bs1_we", 32'(we), 32'd1);
    check("bs1_addr", 32'(addr_a), 32'd0);
    check("bs1_din", 32'(din), 32'h20);
    check("bs1_cursor", 32'(cursor_addr), 32'd0);
    step();

    rx_data  = 8'h41;
    rx_valid = 1'b1;
    step();
    check("b2b_we0", 32'(we), 32'd1);
    check("b2b_addr0", 32'(addr_a), 32'd0);
    rx_data = 8'h42;
    step();
    check("b2b_gap_we", 32'(we), 32'd0);
    step();
    check("b2b_we1", 32'(we), 32'd1);
    check("b2b_addr1", 32'(addr_a), 32'd1);
    check("b2b_din1", 32'(din), 32'h42);
    rx_valid = 1'b0;
    check("b2b_cursor", 32'(cursor_addr), 32'd2);

    send_n(8'h63, 3);
    check("cur5", 32'(cursor_addr), 32'd5);
    send(8'h0D);
    check("cr_we", 32'(we), 32'd0);
    check("cr_cursor", 32'(cursor_addr), 32'd80);

    send(8'h08);
    check("bs80_we", 32'(we), 32'd1);
    check("bs80_addr", 32'(addr_a), 32'd79);
    check("bs80_din", 32'(din), 32'h20);
    check("bs80_cursor", 32'(cursor_addr), 32'd79);

    send_n(8'h0D, 24);
    send_n(8'h78, 70);
    check("cur1990", 32'(cursor_addr), 32'd1990);
    send(8'h0D);
    check("cr_wrap_we", 32'(we), 32'd0);
    check("cr_wrap_cursor", 32'(cursor_addr), 32'd0);

    send(8'h08);
    check("bs0_we", 32'(we), 32'd0);
    check("bs0_cursor", 32'(cursor_addr), 32'd0);

    send_n(8'h0D, 24);
    send_n(8'h79, 79);
    check("cur1999", 32'(cursor_addr), 32'd1999);
    send(8'h5A);
    check("Z_we", 32'(we), 32'd1);
    check("Z_addr", 32'(addr_a), 32'd1999);
    check("Z_din", 32'(din), 32'h5A);
    check("Z_cursor", 32'(cursor_addr), 32'd0);

    send(8'h31);
    send(8'h0A);
    check("lf_we", 32'(we), 32'd0);
    check("lf_cursor", 32'(cursor_addr), 32'd1);
    send(8'h07);
    check("bel_we", 32'(we), 32'd0);
    check("bel_cursor", 32'(cursor_addr), 32'd1);
    step();

    rx_data  = 8'h41;
    rx_valid = 1'b1;
    clr      = 1'b1;
    step();
    clr      = 1'b0;
    rx_valid = 1'b0;
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_rdy", 32'(rx_ready), 32'd0);
    check("clr_no_accept", 32'(cursor_addr), 32'd1);
    cyc  = 0;
    errs = 0;
    while (busy && cyc < 2100) begin
      if (we !== 1'b1 || din !== 8'h20 || addr_a !== 11'(cyc))
        errs++;
      cyc++;
      step();
    end
    check("clr_sweep_errs", 32'(errs), 32'd0);
    check("clr_cycles", 32'(cyc), 32'd2000);
    check("clr_done_we", 32'(we), 32'd0);
    check("clr_done_busy", 32'(busy), 32'd0);
    check("clr_done_cursor", 32'(cursor_addr), 32'd0);
    check("clr_done_rdy", 32'(rx_ready), 32'd1);

    clr = 1'b1;
    step();
    clr = 1'b0;
    cyc = 0;
    while (addr_a !== 11'd700 && cyc < 1000) begin
      step();
      cyc++;
    end
    check("mid_addr", 32'(addr_a), 32'd700);
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_we", 32'(we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdy", 32'(rx_ready), 32'd0);
    check("abort_addr", 32'(addr_a), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rdy", 32'(rx_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
